// File: rtl/reel_scheduler.sv
// reel_scheduler
// Sequences the three slot-machine reels and shares the single sprite ROM
// between them.
//
// Spin control: on a frame tick, every unstopped reel advances its 448-line
// strip offset by SPIN_SPEED. After MIN_SPIN_FRAMES ticks, reels 0, 1 and 2
// are stopped in that order on their target symbols. Reels are separated by
// STOP_STAGGER ticks.
//
// Render lookup: maps a reel-window pixel to a ROM address
// {sprite_idx, x_in_sprite, y_in_sprite}. The address is registered, so it
// is valid one cycle after the request. rgb_valid lines up with the ROM's
// registered pixel output, two cycles after the request.
//
// Ports
//   clk_i            system clock
//   reset_i          asynchronous active-high reset
//   frame_tick_i     one-cycle pulse at vblank start
//   spin_start_i     one-cycle spin request (honoured only when idle)
//   target_sym*_i    stop symbol per reel, sampled on an accepted spin_start
//   busy_o           spin in progress
//   spin_done_o      one-cycle pulse after the last reel stops
//   req_valid_i      render lookup request
//   req_reel_i       reel 0-2; 3 is invalid
//   req_x_i/req_y_i  pixel position inside the reel window
//   sprite_idx_o     ROM sprite select (registered)
//   x_in_sprite_o    ROM column (registered)
//   y_in_sprite_o    ROM row (registered)
//   rgb_valid_o      ROM pixel output is valid this cycle
module reel_scheduler #(
    parameter int unsigned SPIN_SPEED      = 8,
    parameter int unsigned MIN_SPIN_FRAMES = 60,
    parameter int unsigned STOP_STAGGER    = 30
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       frame_tick_i,
    input  logic       spin_start_i,
    input  logic [2:0] target_sym0_i,
    input  logic [2:0] target_sym1_i,
    input  logic [2:0] target_sym2_i,
    output logic       busy_o,
    output logic       spin_done_o,
    input  logic       req_valid_i,
    input  logic [1:0] req_reel_i,
    input  logic [5:0] req_x_i,
    input  logic [5:0] req_y_i,
    output logic [2:0] sprite_idx_o,
    output logic [5:0] x_in_sprite_o,
    output logic [5:0] y_in_sprite_o,
    output logic       rgb_valid_o
);

    localparam int unsigned CNT_W       = 16;
    localparam logic [9:0]  STRIP_LINES = 10'd448;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SPIN,
        S_STOP0,
        S_GAP0,
        S_STOP1,
        S_GAP1,
        S_STOP2,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [2:0][8:0]    off_q, off_d;
    logic [2:0][2:0]    tgt_q, tgt_d;
    logic [2:0]         stopped_q, stopped_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   cnt_inc;
    logic               advance_en;

    // One strip step, with wrap-around at the 448-line boundary.
    function automatic logic [8:0] step_offset(input logic [8:0] off);
        logic [9:0] sum;
        sum = {1'b0, off} + 10'(SPIN_SPEED);
        if (sum >= STRIP_LINES) begin
            sum = sum - STRIP_LINES;
        end
        return sum[8:0];
    endfunction

    // Symbol 7 does not exist on the strip, so it is treated as symbol 0.
    function automatic logic [2:0] clean_target(input logic [2:0] sym);
        return (sym == 3'd7) ? 3'd0 : sym;
    endfunction

    assign cnt_inc    = cnt_q + CNT_W'(1);
    assign advance_en = frame_tick_i && (state_q != S_IDLE) && (state_q != S_DONE);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= S_IDLE;
            off_q     <= '0;
            tgt_q     <= '0;
            stopped_q <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            off_q     <= off_d;
            tgt_q     <= tgt_d;
            stopped_q <= stopped_d;
            cnt_q     <= cnt_d;
        end
    end

    // Reel stepping and spin sequencing. A STOPk state compares against the
    // post-step offset, so the reel lands exactly on its symbol boundary and
    // then holds there.
    always_comb begin
        state_d   = state_q;
        off_d     = off_q;
        tgt_d     = tgt_q;
        stopped_d = stopped_q;
        cnt_d     = cnt_q;

        if (advance_en) begin
            for (int k = 0; k < 3; k++) begin
                if (!stopped_q[k]) begin
                    off_d[k] = step_offset(off_q[k]);
                end
            end
        end

        case (state_q)
            S_IDLE: begin
                if (spin_start_i) begin
                    tgt_d[0]  = clean_target(target_sym0_i);
                    tgt_d[1]  = clean_target(target_sym1_i);
                    tgt_d[2]  = clean_target(target_sym2_i);
                    stopped_d = '0;
                    cnt_d     = '0;
                    state_d   = S_SPIN;
                end
            end
            S_SPIN: begin
                if (frame_tick_i) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == CNT_W'(MIN_SPIN_FRAMES)) begin
                        cnt_d   = '0;
                        state_d = S_STOP0;
                    end
                end
            end
            S_STOP0: begin
                if (frame_tick_i && off_d[0] == {tgt_q[0], 6'd0}) begin
                    stopped_d[0] = 1'b1;
                    cnt_d        = '0;
                    state_d      = S_GAP0;
                end
            end
            S_GAP0: begin
                if (frame_tick_i) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == CNT_W'(STOP_STAGGER)) begin
                        cnt_d   = '0;
                        state_d = S_STOP1;
                    end
                end
            end
            S_STOP1: begin
                if (frame_tick_i && off_d[1] == {tgt_q[1], 6'd0}) begin
                    stopped_d[1] = 1'b1;
                    cnt_d        = '0;
                    state_d      = S_GAP1;
                end
            end
            S_GAP1: begin
                if (frame_tick_i) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == CNT_W'(STOP_STAGGER)) begin
                        cnt_d   = '0;
                        state_d = S_STOP2;
                    end
                end
            end
            S_STOP2: begin
                if (frame_tick_i && off_d[2] == {tgt_q[2], 6'd0}) begin
                    stopped_d[2] = 1'b1;
                    cnt_d        = '0;
                    state_d      = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy_o      = (state_q != S_IDLE);
    assign spin_done_o = (state_q == S_DONE);

    // Lookup path: window row plus reel offset, folded back into the strip.
    logic [8:0] sel_off;
    logic [9:0] line_sum;
    logic [8:0] line;
    logic       req_ok;

    always_comb begin
        sel_off = '0;
        case (req_reel_i)
            2'd0:    sel_off = off_q[0];
            2'd1:    sel_off = off_q[1];
            2'd2:    sel_off = off_q[2];
            default: sel_off = '0;
        endcase
    end

    assign req_ok   = req_valid_i && (req_reel_i != 2'd3);
    assign line_sum = {4'd0, req_y_i} + {1'b0, sel_off};

    always_comb begin
        line = line_sum[8:0];
        if (line_sum >= STRIP_LINES) begin
            line = 9'(line_sum - STRIP_LINES);
        end
    end

    logic [2:0] sprite_idx_q;
    logic [5:0] x_in_sprite_q;
    logic [5:0] y_in_sprite_q;
    logic       addr_valid_q;
    logic       rgb_valid_q;

    // The address only changes on a request, so the ROM keeps seeing a
    // stable address between requests. Reel 3 parks the address at zero.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            sprite_idx_q  <= '0;
            x_in_sprite_q <= '0;
            y_in_sprite_q <= '0;
            addr_valid_q  <= 1'b0;
            rgb_valid_q   <= 1'b0;
        end else begin
            if (req_valid_i) begin
                if (req_ok) begin
                    sprite_idx_q  <= line[8:6];
                    x_in_sprite_q <= req_x_i;
                    y_in_sprite_q <= line[5:0];
                end else begin
                    sprite_idx_q  <= '0;
                    x_in_sprite_q <= '0;
                    y_in_sprite_q <= '0;
                end
            end
            addr_valid_q <= req_ok;
            rgb_valid_q  <= addr_valid_q;
        end
    end

    assign sprite_idx_o  = sprite_idx_q;
    assign x_in_sprite_o = x_in_sprite_q;
    assign y_in_sprite_o = y_in_sprite_q;
    assign rgb_valid_o   = rgb_valid_q;

endmodule

// File: doc/reel_scheduler.md
# reel_scheduler

Sequences the three slot-machine reels and shares the single sprite ROM (64x64 sprites, 7 symbols, 1-cycle registered read) between them. The spin FSM runs on frame ticks: spin up, then stop reels 0, 1 and 2 in order on MCU-supplied target symbols. A render lookup port maps a reel-window pixel to {sprite_idx, x_in_sprite, y_in_sprite} for the ROM, with a valid flag aligned to the ROM pixel output. Sits between the MCU spin interface, the VGA timing block and the sprite ROM.

## Interface
- SPIN_SPEED, 8: pixels per frame each spinning reel advances; power of 2, at most 64
- MIN_SPIN_FRAMES, 60: frame ticks all reels spin before reel 0 is armed
- STOP_STAGGER, 30: frame ticks between a reel stopping and the next reel being armed
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- frame_tick  in  1  one-cycle pulse at vblank start
- spin_start  in  1  one-cycle spin request
- target_sym0/1/2  in  3 each  stop symbol per reel, sampled on accepted spin_start
- busy  out  1  spin in progress
- spin_done  out  1  one-cycle pulse when the last reel stops
- req_valid  in  1  render lookup request
- req_reel  in  2  reel 0-2; 3 is invalid
- req_x  in  6  column in reel window
- req_y  in  6  row in reel window
- sprite_idx  out  3  ROM sprite select, registered
- x_in_sprite  out  6  ROM column, registered
- y_in_sprite  out  6  ROM row, registered
- rgb_valid  out  1  ROM pixel_rgb valid this cycle

## Operation
- Each reel is a 448-line strip (7 x 64). Per-reel offset register off[k] is 9 bits, range 0-447.
- Strip line L = req_y + off[k]. If L >= 448, subtract 448. Then sprite_idx = L[8:6] and y_in_sprite = L[5:0]. x_in_sprite = req_x.
- req_reel = 3 produces outputs of 0 and no rgb_valid.
- FSM states: IDLE, SPIN, STOP0, GAP0, STOP1, GAP1, STOP2, DONE.
- IDLE: spin_start latches targets; any value of 7 is latched as 0. Clears the frame counter, then goes to SPIN. spin_start in any other state is ignored.
- In every state except IDLE and DONE, on frame_tick each unstopped reel advances: off = (off + SPIN_SPEED) mod 448.
- SPIN: counts frame ticks. When the count reaches MIN_SPIN_FRAMES, go to STOP0.
- STOPk: on the frame tick whose new offset equals target_k x 64, reel k stops and holds. The counter clears and the FSM goes to GAPk; from STOP2 it goes to DONE.
- GAPk: counts STOP_STAGGER ticks with the remaining reels still spinning, then goes to STOP(k+1).
- DONE: spin_done = 1 for exactly one cycle, then IDLE. Stopped reels keep their offsets, and the next spin resumes from them.
- busy = 1 in every state except IDLE.

## Timing
- Reset: state IDLE, all offsets 0, counters 0, busy 0, spin_done 0, sprite_idx/x_in_sprite/y_in_sprite 0, rgb_valid 0.
- A reset asserted mid-spin returns everything to these values immediately. No spin_done is issued.
- spin_start accepted at edge N: busy = 1 from N+1.
- Offsets update at the clk edge where frame_tick = 1.
- The edge after the last reel stops enters DONE: spin_done and busy show DONE values that cycle. The following edge returns to IDLE, dropping spin_done and busy together.
- spin_start and frame_tick in the same IDLE cycle: accept the spin; that tick does not advance the reels.
- Lookup latency: ROM address outputs are valid 1 cycle after req_valid. rgb_valid is asserted 2 cycles after req_valid. Fully pipelined, one request per cycle.
- The lookup path reads offsets combinationally. Offsets change only on frame_tick, in vblank.

## Test plan
- Reset: assert reset mid-spin -> every output 0 asynchronously, state IDLE; after release, offsets 0.
- Idle lookup: offsets 0; req reel1 x=5 y=10 -> next cycle sprite_idx 0, x 5, y 10; rgb_valid high 2 cycles after the request. Also send req_reel=3 -> outputs 0 and rgb_valid stays low.
- Wrap lookup: force off[2]=420 via spin, then req y=40 -> line 12, so sprite_idx 0, y_in_sprite 12. Offset 432 + 16 on a tick -> 0.
- Full spin with SPIN_SPEED=16, MIN_SPIN_FRAMES=4, STOP_STAGGER=2, targets 3/0/6 -> final offsets 192/0/384, reels stop in order 0, 1, 2, one spin_done pulse, busy low the cycle after.
- Ignored inputs: spin_start while busy -> targets and state unchanged. Target 7 -> reel stops at offset 0.
- Simultaneous: spin_start and frame_tick in the same cycle from IDLE -> spin accepted, offsets unchanged that cycle.
